// File: rtl/pipe_muldiv_seq_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
//   op encodings : OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
//   state_t      : sequencer FSM states
package pipe_muldiv_seq_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   function automatic logic op_is_div(input logic [1:0] op_code);
      return op_code[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op_code);
      return ~op_code[0];
   endfunction

endpackage

// File: rtl/pipe_muldiv_iter.sv
// One iteration of the unsigned shift-add multiply / restoring divide.
//   acc      : 2*WIDTH working register
//              multiply -> {partial product high, remaining multiplier}
//              divide   -> {partial remainder, remaining dividend/quotient}
//   operand  : multiplicand (multiply) or divisor (divide)
//   div_mode : 1 = divide step, 0 = multiply step
//   acc_next : accumulator after this step; in divide mode bit 0 is left
//              clear and the caller shifts q_bit into it
//   q_bit    : quotient bit produced by a divide step
module pipe_muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   operand,
   input  logic               div_mode,
   output logic [2*WIDTH-1:0] acc_next,
   output logic               q_bit
);

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH-1:0] rem_diff;

   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
      // Partial remainder shifted left one with the next dividend bit; one
      // extra bit so the compare against the divisor cannot overflow.
      rem_shift = acc[2*WIDTH-1:WIDTH-1];
      // Only used when rem_shift >= operand, so the result fits WIDTH bits.
      rem_diff  = rem_shift[WIDTH-1:0] - operand;
      q_bit     = 1'b0;
      acc_next  = '0;
      if (div_mode) begin
         q_bit = (rem_shift >= {1'b0, operand});
         if (q_bit)
            acc_next = {rem_diff, acc[WIDTH-2:0], 1'b0};
         else
            acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         // Carry out of the add becomes the top bit after the right shift.
         acc_next = {mul_sum, acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/pipe_muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO register pair.
// Ports:
//   clock, resetn          : clock, asynchronous active-low reset
//   start, op, a, b        : EX-stage mul/div request and operands
//   cancel                 : flush of the issuing instruction
//   id_hilo_rd, id_muldiv  : ID holds mfhi/mflo or another mul/div
//   hi, lo                 : HI/LO registers
//   busy, done, stall      : in-flight flag, completion pulse, IF/ID hold
//
// state  | meaning
// S_IDLE | waiting for start; done pulse (if any) is visible here
// S_CALC | one unsigned iteration per cycle, WIDTH cycles
// S_FIX  | sign correction and HI/LO write
module pipe_muldiv_seq
   import pipe_muldiv_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   input  logic             id_hilo_rd,
   input  logic             id_muldiv,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]     opnd_q;
   logic                 is_div_q, sign_q, sign_r;
   logic [WIDTH-1:0]     hi_q, lo_q;
   logic                 done_q;

   logic                 accept, last_iter, signed_op;
   logic [WIDTH-1:0]     a_abs, b_abs;
   logic [2*WIDTH-1:0]   iter_acc;
   logic                 iter_q;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo, rem, hi_fix, lo_fix;

   pipe_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .acc      (acc_q),
      .operand  (opnd_q),
      .div_mode (is_div_q),
      .acc_next (iter_acc),
      .q_bit    (iter_q)
   );

   always_comb begin
      signed_op = op_is_signed(op);
      a_abs     = (signed_op && a[WIDTH-1]) ? -a : a;
      b_abs     = (signed_op && b[WIDTH-1]) ? -b : b;
      accept    = (state_q == S_IDLE) && start && !cancel;
      last_iter = (cnt_q == CNT_W'(WIDTH-1));

      prod_fix  = sign_q ? -acc_q : acc_q;
      quo       = acc_q[WIDTH-1:0];
      rem       = acc_q[2*WIDTH-1:WIDTH];
      // A zero divisor yields an all-ones quotient and the raw |dividend| as
      // remainder; re-applying the dividend sign restores hi = a, so only lo
      // needs forcing (the quotient sign would otherwise turn it into 1).
      if (is_div_q) begin
         hi_fix = sign_r ? -rem : rem;
         lo_fix = (opnd_q == '0) ? {WIDTH{1'b1}} : (sign_q ? -quo : quo);
      end else begin
         hi_fix = prod_fix[2*WIDTH-1:WIDTH];
         lo_fix = prod_fix[WIDTH-1:0];
      end

      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_CALC;
         S_CALC:  if (cancel) state_d = S_IDLE;
                  else if (last_iter) state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE: if (accept) begin
               cnt_q    <= '0;
               is_div_q <= op_is_div(op);
               sign_q   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
               sign_r   <= signed_op & a[WIDTH-1];
               if (op_is_div(op)) begin
                  acc_q  <= {{WIDTH{1'b0}}, a_abs};
                  opnd_q <= b_abs;
               end else begin
                  acc_q  <= {{WIDTH{1'b0}}, b_abs};
                  opnd_q <= a_abs;
               end
            end
            S_CALC: if (!cancel) begin
               cnt_q <= cnt_q + CNT_W'(1);
               acc_q <= {iter_acc[2*WIDTH-1:1], is_div_q ? iter_q : iter_acc[0]};
            end
            S_FIX: if (!cancel) begin
               hi_q   <= hi_fix;
               lo_q   <= lo_fix;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign hi    = hi_q;
   assign lo    = lo_q;
   assign done  = done_q;
   assign busy  = (state_q != S_IDLE);
   assign stall = busy & (id_hilo_rd | id_muldiv);

endmodule

// File: tb/tb_pipe_muldiv_seq.sv
module tb_pipe_muldiv_seq;

   logic        clock = 1'b0;
   logic        resetn, start, cancel, id_hilo_rd, id_muldiv;
   logic [1:0]  op;
   logic [31:0] a, b, hi, lo;
   logic        busy, done, stall;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   pipe_muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clock(clock), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
      .cancel(cancel), .id_hilo_rd(id_hilo_rd), .id_muldiv(id_muldiv),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
   );

   // Architectural result of each instruction, from plain integer arithmetic.
   function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] rh, output logic [31:0] rl);
      longint      sx, sy, sp;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      rh = '0; rl = '0;
      case (o)
         2'b00: begin sp = sx * sy; p = sp; rh = p[63:32]; rl = p[31:0]; end
         2'b01: begin p = {32'b0, x} * {32'b0, y}; rh = p[63:32]; rl = p[31:0]; end
         2'b10: if (y == 0) begin rh = x; rl = '1; end
                else begin sp = sx / sy; p = sp; rl = p[31:0]; sp = sx % sy; p = sp; rh = p[31:0]; end
         default: if (y == 0) begin rh = x; rl = '1; end
                  else begin rl = x / y; rh = x % y; end
      endcase
   endfunction

   // Issue one op and observe 40 cycles; reports busy/done counts and HI/LO at done.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rh, output logic [31:0] rl,
                         output int busy_n, output int done_n);
      @(negedge clock);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clock);
      start = 1'b0;
      busy_n = 0; done_n = 0; rh = hi; rl = lo;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) @(negedge clock);
         if (busy) busy_n++;
         if (done) begin done_n++; rh = hi; rl = lo; end
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
      id_hilo_rd = 1'b1; id_muldiv = 1'b1;
      #12;
      n_tests++;
      if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: hi=%h lo=%h busy=%b done=%b stall=%b, want all zero", hi, lo, busy, done, stall);
      end
      @(negedge clock);
      resetn = 1'b1; id_hilo_rd = 1'b0; id_muldiv = 1'b0;
   endtask

   task automatic test_directed();
      logic [1:0]  ops [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b10};
      logic [31:0] xs  [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFB};
      logic [31:0] ys  [6] = '{32'd3, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd0};
      logic [31:0] ehs [6] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd7, 32'h0, 32'hFFFFFFFB};
      logic [31:0] els [6] = '{32'hFFFFFFFA, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
      logic [31:0] rh, rl;
      int bn, dn;
      for (int i = 0; i < 6; i++) begin
         run_op(ops[i], xs[i], ys[i], rh, rl, bn, dn);
         n_tests++;
         if (rh !== ehs[i] || rl !== els[i]) begin
            n_fail++;
            $display("FAIL directed[%0d]: hi=%h lo=%h, want hi=%h lo=%h", i, rh, rl, ehs[i], els[i]);
         end
         n_tests++;
         if (bn !== 33 || dn !== 1) begin
            n_fail++;
            $display("FAIL directed_timing[%0d]: busy_cycles=%0d done_pulses=%0d, want 33 and 1", i, bn, dn);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] x, y, eh, el, rh, rl;
      logic [1:0]  o;
      int bn, dn;
      for (int i = 0; i < 30; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 5))
            0: y = 0;
            1: y = 32'($urandom_range(1, 20));
            2: x = 32'($urandom_range(0, 1000));
            3: y = -32'($urandom_range(1, 20));
            default: ;
         endcase
         ref_model(o, x, y, eh, el);
         run_op(o, x, y, rh, rl, bn, dn);
         n_tests++;
         if (rh !== eh || rl !== el || dn !== 1) begin
            n_fail++;
            $display("FAIL random[%0d] op=%0d a=%h b=%h: hi=%h lo=%h done=%0d, want hi=%h lo=%h done=1",
                     i, o, x, y, rh, rl, dn, eh, el);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic exp_busy, exp_done;
      @(negedge clock);
      id_hilo_rd = 1'b1; id_muldiv = 1'b0;
      start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7;
      for (int k = 0; k < 72; k++) begin
         @(negedge clock);
         start = 1'b0;
         exp_busy = (k < 33) || (k >= 34 && k < 67);
         exp_done = (k == 33) || (k == 67);
         n_tests++;
         if (busy !== exp_busy || done !== exp_done || stall !== exp_busy) begin
            n_fail++;
            $display("FAIL b2b_cycle[%0d]: busy=%b done=%b stall=%b, want busy=%b done=%b stall=%b",
                     k, busy, done, stall, exp_busy, exp_done, exp_busy);
         end
         if (k == 33) begin
            n_tests++;
            if (hi !== 32'd0 || lo !== 32'd42) begin
               n_fail++;
               $display("FAIL b2b_first: hi=%h lo=%h, want 0 and 2a", hi, lo);
            end
            id_hilo_rd = 1'b0; id_muldiv = 1'b1;
            start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
         end
         if (k == 67) begin
            n_tests++;
            if (hi !== 32'd2 || lo !== 32'd14) begin
               n_fail++;
               $display("FAIL b2b_second: hi=%h lo=%h, want 2 and e", hi, lo);
            end
         end
      end
      id_hilo_rd = 1'b0; id_muldiv = 1'b0;
   endtask

   task automatic test_cancel();
      logic [31:0] rh, rl;
      int bn, dn, cpt [2] = '{10, 32};
      run_op(2'b11, 32'h56781234, 32'h00010000, rh, rl, bn, dn);
      n_tests++;
      if (hi !== 32'h1234 || lo !== 32'h5678) begin
         n_fail++;
         $display("FAIL cancel_setup: hi=%h lo=%h, want 1234 and 5678", hi, lo);
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clock);
         start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
         dn = 0;
         for (int k = 0; k < 45; k++) begin
            @(negedge clock);
            start = 1'b0;
            cancel = (k == cpt[c]);
            if (done) dn++;
            if (k == cpt[c] + 1) begin
               n_tests++;
               if (busy !== 1'b0) begin
                  n_fail++;
                  $display("FAIL cancel_idle[%0d]: busy=%b, want 0", cpt[c], busy);
               end
            end
         end
         n_tests++;
         if (dn !== 0 || hi !== 32'h1234 || lo !== 32'h5678) begin
            n_fail++;
            $display("FAIL cancel_hold[%0d]: done_pulses=%0d hi=%h lo=%h, want 0 1234 5678", cpt[c], dn, hi, lo);
         end
      end
      @(negedge clock);
      start = 1'b1; cancel = 1'b1; op = 2'b01;
      @(negedge clock);
      start = 1'b0; cancel = 1'b0;
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL cancel_with_start: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] rh, rl;
      int bn, dn;
      @(negedge clock);
      start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
      @(negedge clock);
      start = 1'b0;
      repeat (5) @(negedge clock);
      #2 resetn = 1'b0;
      #1;
      n_tests++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: busy=%b hi=%h lo=%h done=%b, want all zero", busy, hi, lo, done);
      end
      @(negedge clock);
      resetn = 1'b1;
      run_op(2'b10, 32'd100, 32'd7, rh, rl, bn, dn);
      n_tests++;
      if (rh !== 32'd2 || rl !== 32'd14 || dn !== 1) begin
         n_fail++;
         $display("FAIL after_reset_div: hi=%h lo=%h done=%0d, want 2 e 1", rh, rl, dn);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_cancel();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_muldiv_seq.md
Name: pipe_muldiv_seq

Overview:
Iterative multiply/divide sequencer that owns the HI/LO register pair for the pipelined CPU. It executes mult/multu/div/divu one bit per cycle, with results written to HI/LO on completion. It sits beside the EX stage. The ID control unit takes its stall output into account when mfhi/mflo or a new mul/div reaches ID while an operation is in flight.

Parameters:
WIDTH, 32, operand width; also the iteration count per operation.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clock  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
start  in  1  EX-stage mul/div valid; sampled only in IDLE
op  in  2  00 mult, 01 multu, 10 div, 11 divu
a  in  WIDTH  rs operand (multiplicand or dividend)
b  in  WIDTH  rt operand (multiplier or divisor)
cancel  in  1  pipeline flush of the issuing instruction; aborts in-flight op
id_hilo_rd  in  1  ID holds mfhi or mflo
id_muldiv  in  1  ID holds mult/multu/div/divu
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  operation in flight
done  out  1  one-cycle pulse; HI/LO updated on this edge
stall  out  1  hold IF/ID; equals busy & (id_hilo_rd | id_muldiv)

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators=0.
  - Reset asserted mid-operation discards the operation.
- States: IDLE, CALC, FIX.
- IDLE:
  - On start=1 & cancel=0, latch |a|, |b| (signed ops) or a, b (unsigned ops).
  - Latch sign_q = a[W-1]^b[W-1] and sign_r = a[W-1], both for signed ops only; latch op.
  - Clear counter and go to CALC.
- CALC: one iteration per cycle, counter increments.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient bit = 1 when the partial remainder is >= the divisor.
  - After WIDTH iterations (counter==WIDTH-1 at the edge), go to FIX.
- FIX:
  - Apply sign correction using two's-complement negation modulo 2^WIDTH:
    - mult: {hi,lo} = sign_q ? -P : P.
    - div: lo = sign_q ? -Q : Q; hi = sign_r ? -R : R.
  - Write hi/lo, assert done for this one cycle, return to IDLE.
- Latency: start sampled at edge T, then CALC edges T+1..T+WIDTH, then the FIX edge T+WIDTH+1 writes hi/lo. done is high in the cycle following the FIX edge.
- busy is 1 from the edge after the start sample until the FIX edge inclusive; it is 0 in the cycle where done is high.
- Back-to-back: start is accepted in the cycle done=1 (state is IDLE).
- start while busy: ignored. Stall holds that instruction in ID, so this only occurs on a protocol violation.
- cancel=1 in CALC or FIX: return to IDLE next edge. hi/lo unchanged, no done pulse.
- cancel=1 together with start in IDLE: start ignored.
- Divide by zero (b==0): hi = a (raw dividend), lo = {WIDTH{1}}. Full latency is still taken; no exception.
- Signed overflow, div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the abs/negate path.
- Readers see the old hi/lo until the FIX edge. The hi/lo read mux (and any mfhi-from-EX forwarding) is outside this block.

Decomposition:
- Shared package holds:
  - the op encodings (OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11);
  - the state encodings (S_IDLE, S_CALC, S_FIX).
- One natural sub-module, pipe_muldiv_iter: the per-cycle shift-add / shift-subtract step.
  - Combinational, inputs: accumulator, operand, mode.
  - Outputs: next accumulator and quotient bit.
- The FSM, counter, sign handling and HI/LO registers stay in pipe_muldiv_seq.

Test Plan:
- mult a=0xFFFFFFFE (-2), b=3 -> after WIDTH+1 edges: hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses exactly once; busy high for 33 cycles.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- div a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu a=7, b=0 -> hi=7, lo=0xFFFFFFFF.
- id_hilo_rd=1 throughout an in-flight op -> stall=1 every busy cycle, stall=0 in the done cycle; a second start issued in the done cycle is accepted.
- Assert cancel at iteration 10 of a mult after hi/lo hold 0x1234/0x5678 -> state IDLE next edge, hi/lo unchanged, no done, busy=0.
- Drop resetn mid-CALC (asynchronously, between edges) -> busy=0, hi=lo=0 immediately. After release, a fresh div 100/7 gives lo=14, hi=2.
